// File: rtl/prio_enc_rr_q_if.sv
// Request/grant bundle for prio_enc_rr_q: request lines and mode inputs in,
// registered grant, pending status and merge pulse out.
interface prio_enc_rr_q_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic         rr_en;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic [W:0]   pend_cnt;
    logic         any_pend;
    logic         ovf;

    modport master (
        output req, rr_en, out_ready,
        input  out_valid, out_idx, out_onehot, pend_cnt, any_pend, ovf
    );

    modport slave (
        input  req, rr_en, out_ready,
        output out_valid, out_idx, out_onehot, pend_cnt, any_pend, ovf
    );
endinterface

// File: rtl/prio_enc_rr_q.sv
// Sticky pending register feeding a one-deep registered grant stage; the grant
// is picked by fixed priority (highest index) or a descending round-robin pointer.
module prio_enc_rr_q #(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    prio_enc_rr_q_if.slave    bus
);
    localparam int W  = $clog2(N);
    localparam int CW = W + 1;

    logic [N-1:0]  pend_q, pend_d;
    logic [W-1:0]  ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_idx_q, out_idx_d;
    logic [N-1:0]  out_onehot_q, out_onehot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          any_q, any_d;
    logic          ovf_q, ovf_d;

    logic          any_pend_comb;
    logic          load;
    logic [W-1:0]  sel, sel_fixed, sel_rr;
    logic [N-1:0]  load_mask;

    assign any_pend_comb = |pend_q;

    always_comb begin
        sel_fixed = '0;
        for (int i = 0; i < N; i++) begin
            if (pend_q[i]) sel_fixed = W'(i);
        end
    end

    // Walk downward from ptr, wrapping past 0 to N-1; first pending bit wins.
    always_comb begin
        logic found;
        int   idx;
        sel_rr = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + N - i) % N;
            if (!found && pend_q[idx]) begin
                sel_rr = W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign sel  = bus.rr_en ? sel_rr : sel_fixed;
    assign load = any_pend_comb & (~out_valid_q | bus.out_ready);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign load_mask[gi] = load & (sel == W'(gi));
        end
    endgenerate

    // A fresh request on the bit being granted keeps it pending.
    assign pend_d = bus.req | (pend_q & ~load_mask);
    assign ovf_d  = |(bus.req & pend_q & ~load_mask);
    assign any_d  = |pend_d;

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d = cnt_d + CW'(pend_d[i]);
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_onehot_d = out_onehot_q;
        if (load) begin
            out_valid_d  = 1'b1;
            out_idx_d    = sel;
            out_onehot_d = load_mask;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d  = 1'b0;
            out_onehot_d = '0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load && bus.rr_en) begin
            ptr_d = (sel == '0) ? W'(N - 1) : sel - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            ptr_q        <= W'(N - 1);
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            cnt_q        <= '0;
            any_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            ptr_q        <= ptr_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
            cnt_q        <= cnt_d;
            any_q        <= any_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_onehot = out_onehot_q;
    assign bus.pend_cnt   = cnt_q;
    assign bus.any_pend   = any_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_prio_enc_rr_q.sv
// Self-checking bench for prio_enc_rr_q (N=8): vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_prio_enc_rr_q;
    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    prio_enc_rr_q_if #(.N(N)) bus ();

    prio_enc_rr_q #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: pending set as a bit array, grant held as valid + index.
    bit m_pend [N];
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_cnt;
    bit m_ovf;

    typedef struct {
        logic [7:0] req;
        bit         rr;
        bit         rdy;
        bit         ev;
        int         ei;
        int         ec;
        bit         eo;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = N - 1;
        m_cnt   = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step();
        int  s;
        bit  ld;
        bit  np [N];
        s = -1;
        if (bus.rr_en) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr - k + N) % N;
                if (s < 0 && m_pend[p]) s = p;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (s < 0 && m_pend[i]) s = i;
            end
        end
        ld    = (s >= 0) && (!m_valid || bus.out_ready);
        m_ovf = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < N; i++) begin
            bit granted;
            granted = ld && (i == s);
            if (bus.req[i] && m_pend[i] && !granted) m_ovf = 1'b1;
            np[i] = bus.req[i] || (m_pend[i] && !granted);
            if (np[i]) m_cnt++;
        end
        m_pend = np;
        if (ld) begin
            m_valid = 1'b1;
            m_idx   = s;
            if (bus.rr_en) m_ptr = (s == 0) ? N - 1 : s - 1;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_model();
        int exp_oh;
        exp_oh = m_valid ? (1 << m_idx) : 0;
        chk("out_valid", int'(bus.out_valid), int'(m_valid));
        chk("out_idx", int'(bus.out_idx), m_idx);
        chk("out_onehot", int'(bus.out_onehot), exp_oh);
        chk("pend_cnt", int'(bus.pend_cnt), m_cnt);
        chk("any_pend", int'(bus.any_pend), int'(m_cnt != 0));
        chk("ovf", int'(bus.ovf), int'(m_ovf));
        chk("ptr", int'(dut.ptr_q), m_ptr);
    endtask

    task automatic tick();
        if (bus.out_valid && bus.out_ready)
            $display("accept idx=%0d rr=%0d t=%0t", bus.out_idx, bus.rr_en, $time);
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drive(input logic [7:0] r, input bit rr, input bit rdy);
        bus.req       = r;
        bus.rr_en     = rr;
        bus.out_ready = rdy;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Fixed priority drain, then backpressure on the same pattern.
        tbl.push_back('{8'h25, 0, 1, 0, 0, 3, 0});
        tbl.push_back('{8'h00, 0, 1, 1, 5, 2, 0});
        tbl.push_back('{8'h00, 0, 1, 1, 2, 1, 0});
        tbl.push_back('{8'h00, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{8'h00, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{8'h25, 0, 0, 0, 0, 3, 0});
        for (int i = 0; i < 5; i++) tbl.push_back('{8'h00, 0, 0, 1, 5, 2, 0});
        tbl.push_back('{8'h00, 0, 1, 1, 2, 1, 0});
        tbl.push_back('{8'h00, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{8'h00, 0, 1, 0, 0, 0, 0});
        // Round-robin with all lines held: merges raise ovf every grant cycle.
        tbl.push_back('{8'hFF, 1, 1, 0, 0, 8, 0});
        for (int i = 0; i < 10; i++) tbl.push_back('{8'hFF, 1, 1, 1, (7 - i + 16) % 8, 8, 1});
        for (int i = 0; i < 3; i++) tbl.push_back('{8'hFF, 0, 1, 1, 7, 8, 1});

        drive(8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset: everything stays zero, pointer parked at N-1.
        chk("rst_ptr", int'(dut.ptr_q), 7);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_valid", int'(bus.out_valid), 0);
            chk("idle_cnt", int'(bus.pend_cnt), 0);
            chk("idle_onehot", int'(bus.out_onehot), 0);
        end

        foreach (tbl[r]) begin
            drive(tbl[r].req, tbl[r].rr, tbl[r].rdy);
            tick();
            chk($sformatf("vec%0d_valid", r), int'(bus.out_valid), int'(tbl[r].ev));
            chk($sformatf("vec%0d_idx", r), int'(bus.out_idx), tbl[r].ei);
            chk($sformatf("vec%0d_cnt", r), int'(bus.pend_cnt), tbl[r].ec);
            chk($sformatf("vec%0d_ovf", r), int'(bus.ovf), int'(tbl[r].eo));
        end

        drive(8'h00, 1'b0, 1'b1);
        repeat (12) tick();

        // Merge: bit 3 sits in the output stage, a second pulse re-pends it,
        // a third pulse hits the pending bit and is merged (single ovf cycle).
        drive(8'h08, 1'b0, 1'b0); tick();
        chk("m1_cnt", int'(bus.pend_cnt), 1);
        drive(8'h00, 1'b0, 1'b0); tick();
        chk("m1_valid", int'(bus.out_valid), 1);
        chk("m1_idx", int'(bus.out_idx), 3);
        chk("m1_cnt0", int'(bus.pend_cnt), 0);
        drive(8'h08, 1'b0, 1'b0); tick();
        chk("m2_ovf", int'(bus.ovf), 0);
        chk("m2_cnt", int'(bus.pend_cnt), 1);
        drive(8'h00, 1'b0, 1'b0); tick();
        drive(8'h08, 1'b0, 1'b0); tick();
        chk("m3_ovf", int'(bus.ovf), 1);
        chk("m3_cnt", int'(bus.pend_cnt), 1);
        drive(8'h00, 1'b0, 1'b0); tick();
        chk("m3_ovf_drop", int'(bus.ovf), 0);
        chk("m3_idx_hold", int'(bus.out_idx), 3);
        drive(8'h00, 1'b0, 1'b1);
        repeat (4) tick();

        // Asynchronous reset between edges with traffic in flight.
        drive(8'hFF, 1'b0, 1'b0);
        repeat (3) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", int'(bus.out_valid), 0);
        chk("arst_onehot", int'(bus.out_onehot), 0);
        chk("arst_cnt", int'(bus.pend_cnt), 0);
        chk("arst_any", int'(bus.any_pend), 0);
        chk("arst_ovf", int'(bus.ovf), 0);
        chk("arst_ptr", int'(dut.ptr_q), 7);
        @(posedge clk);
        #1;
        drive(8'h00, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("post_rst_valid", int'(bus.out_valid), 0);
        end

        for (int c = 0; c < 2000; c++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = 8'h00;
            if ($urandom_range(0, 15) == 0) bus.rr_en = ~bus.rr_en;
            bus.req       = r;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
